spike_count_classifier: RTL and testbench
=========================================

Name: spike_count_classifier

Overview:
- Output-decoding stage directly downstream of the 3-layer fully connected spiking network.
- Consumes the final layer's per-class spike vector each clock-enabled timestep.
- Accumulates per-class spike counts over a programmable window, then runs a sequential argmax and reports the winning class, its count and a tie flag.
- Turns the network's spike trains into a classification result for the host or the scan chain.

Parameters:
- NUM_CLASSES, 10, number of output neurons/classes (width of spike_in).
- COUNT_BITS, 8, width of each per-class saturating spike counter.
- WINDOW_BITS, 8, width of window_len and the internal timestep counter.
- IDX_BITS, $clog2(NUM_CLASSES), width of class_out (derived, shared package).

Ports:
- clk  input  1  single system clock; all state updates on rising edge.
- rst_n  input  1  reset, synchronous, active-low.
- ce  input  1  timestep enable; same ce that advances the network.
- start  input  1  begin a classification window; sampled only in IDLE.
- window_len  input  WINDOW_BITS  number of ce timesteps to accumulate; latched on start.
- spike_in  input  NUM_CLASSES  final-layer spike vector, bit k = class k.
- busy  output  1  high in ACCUM, ARGMAX and DONE.
- class_valid  output  1  one-cycle pulse when a result is presented.
- class_out  output  IDX_BITS  winning class index.
- max_count  output  COUNT_BITS  spike count of the winning class.
- tie  output  1  another class equals max_count.

Behaviour:
- Reset (rst_n=0 at a clk edge) applies at any time, including mid-window:
  - state=IDLE; all counters, step counter and scan index cleared.
  - busy=0, class_valid=0, class_out=0, max_count=0, tie=0.
- FSM states: IDLE, ACCUM, ARGMAX, DONE.
- IDLE:
  - start=1 clears all class counters, latches window_len and clears the step counter; next state ACCUM.
  - window_len=0 is latched as 1.
  - spike_in in the start cycle is not counted.
  - Result outputs hold their previous values until the next DONE.
- ACCUM:
  - On each cycle with ce=1, counter[k] += spike_in[k] for all k, saturating at 2^COUNT_BITS-1 (no wrap). The step counter increments.
  - On the ce=1 cycle that completes step window_len, go to ARGMAX; that cycle's spikes are counted.
  - With ce=0, nothing changes.
- ARGMAX:
  - Independent of ce. Scans index i = 0..NUM_CLASSES-1, one class per clock.
  - i=0 loads best=0, bestcnt=counter[0], tie=0.
  - For i>0:
    - counter[i] > bestcnt: best=i, bestcnt=counter[i], tie=0.
    - counter[i] == bestcnt: tie=1, best unchanged, so the lowest index wins.
  - After i=NUM_CLASSES-1, go to DONE.
- DONE:
  - Lasts one cycle: class_valid=1; class_out, max_count and tie are registered with the final scan result. Next state IDLE.
  - All-zero counts yield class_out=0, max_count=0, tie=1 when NUM_CLASSES>1.
- Latency with ce held high, start sampled at cycle 0:
  - ACCUM covers cycles 1..W; ARGMAX covers W+1..W+N; class_valid is high at cycle W+N+1.
  - W = latched window_len, N = NUM_CLASSES.
- Other rules:
  - start while busy=1 is ignored, with no restart or abort.
  - window_len changes after start have no effect.
  - Counters are not cleared at DONE, only at the next start.

Decomposition:
- Shared package snn_pkg:
  - FSM state enum (IDLE/ACCUM/ARGMAX/DONE).
  - Defaults for NUM_CLASSES, COUNT_BITS, WINDOW_BITS.
  - IDX_BITS derivation.
  - Saturation max constant.
- One natural sub-module, sat_spike_counter: COUNT_BITS counter with clear, increment-enable and saturation; instantiated NUM_CLASSES times via generate.
- FSM, step counter and argmax scan stay in the top module.

Test Plan:
- Winner: window_len=5, ce=1; class 3 spikes every step, class 7 on 2 steps, others silent -> class_valid at cycle 5+10+1=16, class_out=3, max_count=5, tie=0.
- Tie: window_len=4; classes 2 and 6 both spike 4 times -> class_out=2, max_count=4, tie=1.
- Saturation: COUNT_BITS=8, window_len=255 then a second run with a 20-step window on top of uncleared counts (verify clear on start); all-ones spike_in for 255 steps -> max_count=255, no wrap, class_out=0, tie=1.
- ce gating: window_len=3, ce toggling 1,0,1,0,1 with class 9 spiking every cycle -> count=3, class_out=9; class_valid delayed by the ce=0 cycles.
- Reset mid-window: rst_n=0 during ACCUM after 2 steps -> next cycle busy=0, all outputs 0; new start with window_len=1 yields a fresh result without the stale counts.
- start ignored while busy, and window_len=0: pulse start during ARGMAX -> no restart, a single class_valid; a separate start with window_len=0 behaves as 1 step (class_valid at cycle 1+10+1=12).

Source files
------------

// File: rtl/snn_pkg.sv
// snn_pkg: shared types and defaults for the spiking-network output stage
package snn_pkg;
   localparam int NUM_CLASSES_DEF = 10;
   localparam int COUNT_BITS_DEF  = 8;
   localparam int WINDOW_BITS_DEF = 8;
   localparam logic [COUNT_BITS_DEF-1:0] SAT_MAX = '1;
   typedef enum logic [1:0] {IDLE, ACCUM, ARGMAX, DONE} state_t;
   function automatic int idx_bits(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction
endpackage

// File: rtl/sat_spike_counter.sv
// sat_spike_counter: per-class spike counter with clear and saturation
module sat_spike_counter #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         clr,
   input  logic         inc,
   output logic [W-1:0] cnt
);
   always_ff @(posedge clk)
      if (!rst_n || clr) cnt <= '0;
      else if (inc && !(&cnt)) cnt <= cnt + 1'b1;
endmodule

// File: rtl/spike_count_classifier.sv
// spike_count_classifier: windowed spike counting followed by a sequential argmax
module spike_count_classifier
   import snn_pkg::*;
#(
   parameter int NUM_CLASSES = NUM_CLASSES_DEF,
   parameter int COUNT_BITS  = COUNT_BITS_DEF,
   parameter int WINDOW_BITS = WINDOW_BITS_DEF,
   parameter int IDX_BITS    = idx_bits(NUM_CLASSES)
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   ce,
   input  logic                   start,
   input  logic [WINDOW_BITS-1:0] window_len,
   input  logic [NUM_CLASSES-1:0] spike_in,
   output logic                   busy,
   output logic                   class_valid,
   output logic [IDX_BITS-1:0]    class_out,
   output logic [COUNT_BITS-1:0]  max_count,
   output logic                   tie
);
   localparam logic [IDX_BITS-1:0] LAST = IDX_BITS'(NUM_CLASSES - 1);
   state_t                  state, nxt;
   logic [WINDOW_BITS-1:0]  win, step;
   logic [IDX_BITS-1:0]     idx, best, nb;
   logic [COUNT_BITS-1:0]   bc, nc, cur;
   logic                    tie_r, nt, first, gt;
   logic [COUNT_BITS-1:0]   cnt [NUM_CLASSES];
   logic                    clr, acc;

   assign clr = (state == IDLE) && start;
   assign acc = (state == ACCUM) && ce;
   assign busy = state != IDLE;
   assign class_valid = state == DONE;

   for (genvar k = 0; k < NUM_CLASSES; k++) begin : g_cnt
      sat_spike_counter #(.W(COUNT_BITS)) u_cnt (
         .clk   (clk),
         .rst_n (rst_n),
         .clr   (clr),
         .inc   (acc && spike_in[k]),
         .cnt   (cnt[k])
      );
   end

   // strict greater-than keeps the lowest index on equal counts
   always_comb begin
      cur   = cnt[idx];
      first = idx == '0;
      gt    = cur > bc;
      nb    = first ? '0 : (gt ? idx : best);
      nc    = first ? cur : (gt ? cur : bc);
      nt    = first ? 1'b0 : (gt ? 1'b0 : ((cur == bc) ? 1'b1 : tie_r));
   end

   always_comb begin
      nxt = state;
      case (state)
         IDLE:   nxt = start ? ACCUM : IDLE;
         ACCUM:  nxt = (ce && step == win - 1'b1) ? ARGMAX : ACCUM;
         ARGMAX: nxt = (idx == LAST) ? DONE : ARGMAX;
         default: nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state     <= IDLE;
         win       <= '0;
         step      <= '0;
         idx       <= '0;
         best      <= '0;
         bc        <= '0;
         tie_r     <= 1'b0;
         class_out <= '0;
         max_count <= '0;
         tie       <= 1'b0;
      end else begin
         state <= nxt;
         if (clr) begin
            win  <= (window_len == '0) ? WINDOW_BITS'(1) : window_len;
            step <= '0;
            idx  <= '0;
         end
         if (acc) step <= step + 1'b1;
         if (state == ARGMAX) begin
            best  <= nb;
            bc    <= nc;
            tie_r <= nt;
            idx   <= idx + 1'b1;
            if (idx == LAST) begin
               class_out <= nb;
               max_count <= nc;
               tie       <= nt;
            end
         end
      end
   end
endmodule

// File: tb/tb_spike_count_classifier.sv
// tb_spike_count_classifier: directed checks of window accumulation, argmax, ties and saturation
module tb_spike_count_classifier;
   logic       clk = 1'b0, rst_n = 1'b0, ce = 1'b1, start = 1'b0;
   logic [7:0] window_len = '0;
   logic [9:0] spike_in = '0;
   logic       busy, class_valid, tie;
   logic [3:0] class_out;
   logic [7:0] max_count;
   logic       busy_s, class_valid_s, tie_s;
   logic [3:0] class_out_s;
   logic [3:0] max_count_s;
   int         checks = 0, errors = 0, n = 0, pulses = 0;

   spike_count_classifier dut (
      .clk(clk), .rst_n(rst_n), .ce(ce), .start(start), .window_len(window_len),
      .spike_in(spike_in), .busy(busy), .class_valid(class_valid),
      .class_out(class_out), .max_count(max_count), .tie(tie)
   );

   // narrow-counter copy so saturation can actually be exceeded
   spike_count_classifier #(.COUNT_BITS(4)) dut_s (
      .clk(clk), .rst_n(rst_n), .ce(ce), .start(start), .window_len(window_len),
      .spike_in(spike_in), .busy(busy_s), .class_valid(class_valid_s),
      .class_out(class_out_s), .max_count(max_count_s), .tie(tie_s)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic begin_win(input logic [7:0] wl);
      start = 1'b1;
      window_len = wl;
      spike_in = 10'h3FF;
      tick();
      start = 1'b0;
      window_len = 8'd77;
      spike_in = '0;
   endtask

   task automatic wait_valid(output int cnt);
      cnt = 0;
      while (!class_valid && cnt < 400) begin
         tick();
         cnt++;
      end
   endtask

   initial begin
      tick();
      tick();
      chk("rst_busy", busy, 0);
      chk("rst_valid", class_valid, 0);
      chk("rst_class", class_out, 0);
      chk("rst_max", max_count, 0);
      chk("rst_tie", tie, 0);
      rst_n = 1'b1;
      tick();

      // winner: class 3 every step, class 7 on two steps
      begin_win(8'd5);
      chk("win_busy", busy, 1);
      for (int i = 0; i < 5; i++) begin
         spike_in = 10'b0000001000 | ((i < 2) ? 10'b0010000000 : 10'b0);
         tick();
      end
      spike_in = '0;
      wait_valid(n);
      chk("win_latency", n, 10);
      chk("win_valid", class_valid, 1);
      chk("win_class", class_out, 3);
      chk("win_max", max_count, 5);
      chk("win_tie", tie, 0);
      tick();
      chk("win_pulse", class_valid, 0);
      chk("win_idle", busy, 0);

      // tie between classes 2 and 6
      begin_win(8'd4);
      chk("hold_class", class_out, 3);
      for (int i = 0; i < 4; i++) begin
         spike_in = 10'b0001000100;
         tick();
      end
      spike_in = '0;
      wait_valid(n);
      chk("tie_class", class_out, 2);
      chk("tie_max", max_count, 4);
      chk("tie_tie", tie, 1);
      tick();

      // saturation over a full 255-step window
      begin_win(8'd255);
      spike_in = 10'h3FF;
      for (int i = 0; i < 255; i++) tick();
      spike_in = '0;
      wait_valid(n);
      chk("sat_max", max_count, 255);
      chk("sat_class", class_out, 0);
      chk("sat_tie", tie, 1);
      chk("sat4_max", max_count_s, 15);
      tick();

      // 20-step window after saturation: counters must restart from zero
      begin_win(8'd20);
      spike_in = 10'h3FF;
      for (int i = 0; i < 20; i++) tick();
      spike_in = '0;
      wait_valid(n);
      chk("clr_max", max_count, 20);
      chk("clr_tie", tie, 1);
      chk("sat4_20_max", max_count_s, 15);
      tick();

      // ce gating with class 9 spiking every cycle
      begin_win(8'd3);
      spike_in = 10'h200;
      for (int i = 0; i < 5; i++) begin
         ce = (i % 2 == 0);
         tick();
      end
      ce = 1'b1;
      spike_in = '0;
      wait_valid(n);
      chk("ce_latency", n, 10);
      chk("ce_class", class_out, 9);
      chk("ce_max", max_count, 3);
      chk("ce_tie", tie, 0);
      tick();

      // reset mid-window
      begin_win(8'd8);
      spike_in = 10'h020;
      tick();
      tick();
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      spike_in = '0;
      chk("mid_rst_busy", busy, 0);
      chk("mid_rst_class", class_out, 0);
      chk("mid_rst_max", max_count, 0);
      chk("mid_rst_tie", tie, 0);
      begin_win(8'd1);
      spike_in = 10'h010;
      tick();
      spike_in = '0;
      wait_valid(n);
      chk("post_rst_class", class_out, 4);
      chk("post_rst_max", max_count, 1);
      chk("post_rst_tie", tie, 0);
      tick();

      // start during ARGMAX is ignored
      begin_win(8'd2);
      spike_in = 10'h002;
      tick();
      tick();
      spike_in = '0;
      tick();
      tick();
      start = 1'b1;
      window_len = 8'd3;
      tick();
      start = 1'b0;
      pulses = 0;
      for (int i = 0; i < 30; i++) begin
         if (class_valid) begin
            pulses++;
            chk("ign_class", class_out, 1);
            chk("ign_max", max_count, 2);
         end
         tick();
      end
      chk("ign_pulses", pulses, 1);
      chk("ign_idle", busy, 0);

      // window_len=0 acts as a single step
      begin_win(8'd0);
      spike_in = 10'h100;
      tick();
      spike_in = '0;
      wait_valid(n);
      chk("zero_latency", n, 10);
      chk("zero_class", class_out, 8);
      chk("zero_max", max_count, 1);
      chk("zero_tie", tie, 0);
      tick();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
